// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Optional misalign checking is enabled with PC_GEN_MISALIGN_CHECK_EN.
package pc_gen_pkg;

  typedef enum logic {
    S_BOOT,
    S_RUN
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam int unsigned DEFAULT_STEP = 4;

  typedef logic [1:0] redir_cause_t;

  localparam redir_cause_t REDIR_EXC = 2'd0;
  localparam redir_cause_t REDIR_BR  = 2'd1;
  localparam redir_cause_t REDIR_JMP = 2'd2;

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect select; channel 0 wins.
// Reports any_redir, the winning index and its target.
module pc_redir_arb #(
  parameter int ADDR_W  = 32,
  parameter int N_REDIR = 3,
  parameter int SEL_W   = (N_REDIR > 1) ? $clog2(N_REDIR) : 1
) (
  input  logic [N_REDIR-1:0]        redir_valid,
  input  logic [N_REDIR*ADDR_W-1:0] redir_addr,
  output logic                      any_redir,
  output logic [SEL_W-1:0]          sel,
  output logic [ADDR_W-1:0]         sel_addr
);

  assign any_redir = |redir_valid;

  // Scan high to low so the lowest valid index is written last.
  always_comb begin
    sel      = '0;
    sel_addr = '0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel      = SEL_W'(i);
        sel_addr = redir_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects, stall-pending capture,
// valid/ready fetch handshake. Macro: PC_GEN_MISALIGN_CHECK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC =
    ADDR_W'(DEFAULT_RESET_VEC),
  parameter int STEP    = DEFAULT_STEP,
  parameter int N_REDIR = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [N_REDIR-1:0]        redir_valid,
  input  logic [N_REDIR*ADDR_W-1:0] redir_addr,
  input  logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [ADDR_W-1:0]         pc_address,
  output logic                      pc_redirected,
  output logic                      misalign_err
);

  localparam int SEL_W = (N_REDIR > 1) ? $clog2(N_REDIR) : 1;

  pc_state_e state, state_nxt;

  logic              any_redir;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] tgt_addr;
  logic              tgt_mis;

  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic              pend_mis, pend_mis_nxt;
  logic              redir_q, redir_nxt;
  logic              mis_q, mis_nxt;

  logic unused_sel;
  assign unused_sel = ^sel;

  pc_redir_arb #(
    .ADDR_W (ADDR_W),
    .N_REDIR(N_REDIR),
    .SEL_W  (SEL_W)
  ) u_arb (
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .any_redir  (any_redir),
    .sel        (sel),
    .sel_addr   (sel_addr)
  );

`ifdef PC_GEN_MISALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);
  assign tgt_addr = sel_addr & ~LOW_MASK;
  assign tgt_mis  = |(sel_addr & LOW_MASK);
`else
  assign tgt_addr = sel_addr;
  assign tgt_mis  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fetch_valid = 1'b0;
    unique case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN:  fetch_valid = !stall;
      default: state_nxt = S_BOOT;
    endcase
  end

  // First matching rule wins; stall only ever touches pending state.
  always_comb begin
    pc_nxt         = pc_q;
    pend_valid_nxt = pend_valid;
    pend_addr_nxt  = pend_addr;
    pend_mis_nxt   = pend_mis;
    redir_nxt      = 1'b0;
    mis_nxt        = 1'b0;
    if (stall && any_redir) begin
      pend_valid_nxt = 1'b1;
      pend_addr_nxt  = tgt_addr;
      pend_mis_nxt   = tgt_mis;
    end else if (stall) begin
      pc_nxt = pc_q;
    end else if (any_redir) begin
      pc_nxt         = tgt_addr;
      pend_valid_nxt = 1'b0;
      pend_mis_nxt   = 1'b0;
      redir_nxt      = 1'b1;
      mis_nxt        = tgt_mis;
    end else if (pend_valid) begin
      pc_nxt         = pend_addr;
      pend_valid_nxt = 1'b0;
      pend_mis_nxt   = 1'b0;
      redir_nxt      = 1'b1;
      mis_nxt        = pend_mis;
    end else if (fetch_valid && fetch_ready) begin
      pc_nxt = pc_q + ADDR_W'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_mis   <= 1'b0;
      redir_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_nxt;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
      pend_mis   <= pend_mis_nxt;
      redir_q    <= redir_nxt;
      mis_q      <= mis_nxt;
    end
  end

  assign pc_address    = pc_q;
  assign pc_redirected = redir_q;
  assign misalign_err  = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed + random bench for pc_gen with a behavioural reference.
// Honours PC_GEN_MISALIGN_CHECK_EN when expecting misalign results.
module tb_pc_gen;

  localparam int          AW   = 32;
  localparam int          NR   = 3;
  localparam int unsigned STP  = 4;
  localparam logic [31:0] RVEC = 32'h0000_1000;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           stall;
  logic [NR-1:0]  redir_valid;
  logic [NR*AW-1:0] redir_addr;
  logic           fetch_ready;
  logic           fetch_valid;
  logic [AW-1:0]  pc_address;
  logic           pc_redirected;
  logic           misalign_err;

  int compared = 0;
  int mismatched = 0;

  // reference state
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pa;
  bit          m_pm;
  bit          m_red;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W   (AW),
    .RESET_VEC(RVEC),
    .STEP     (STP),
    .N_REDIR  (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_addr   (redir_addr),
    .fetch_ready  (fetch_ready),
    .fetch_valid  (fetch_valid),
    .pc_address   (pc_address),
    .pc_redirected(pc_redirected),
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic [2:0] rv,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input bit rdy);
    stall       = s;
    redir_valid = rv;
    redir_addr  = {a2, a1, a0};
    fetch_ready = rdy;
  endtask

  // One clock: check fetch_valid, advance the model, check registers.
  task automatic cycle(input string tag);
    bit          fv, any, tm;
    logic [31:0] t, tal;
    #1;
    fv = !m_boot && !stall;
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
    any = 1'b0;
    t   = '0;
    for (int i = 0; i < NR; i++) begin
      if (!any && redir_valid[i]) begin
        any = 1'b1;
        t   = redir_addr[i*AW +: AW];
      end
    end
    tm  = MIS_EN && (t % STP != 0);
    tal = MIS_EN ? t - (t % STP) : t;
    if (rst) begin
      m_boot = 1; m_pc = RVEC; m_pv = 0; m_pa = 0;
      m_pm = 0; m_red = 0; m_mis = 0;
    end else begin
      m_red = 0;
      m_mis = 0;
      if (stall && any) begin
        m_pv = 1; m_pa = tal; m_pm = tm;
      end else if (stall) begin
      end else if (any) begin
        m_pc = tal; m_pv = 0; m_red = 1; m_mis = tm;
      end else if (m_pv) begin
        m_pc = m_pa; m_pv = 0; m_red = 1; m_mis = m_pm;
      end else if (fv && fetch_ready) begin
        m_pc = m_pc + STP;
      end
      m_boot = 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc_address, m_pc);
    chk({tag, ".redir"}, 32'(pc_redirected), 32'(m_red));
    chk({tag, ".mis"}, 32'(misalign_err), 32'(m_mis));
    @(negedge clk);
  endtask

  initial begin
    m_boot = 1; m_pc = RVEC; m_pv = 0; m_pa = 0;
    m_pm = 0; m_red = 0; m_mis = 0;
    rst = 1'b1;
    drive(0, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    cycle("reset");
    chk("reset.pc_const", pc_address, 32'h1000);
    rst = 1'b0;

    // boot bubble then sequential fetch
    drive(0, 3'b000, 0, 0, 0, 1);
    #1;
    chk("boot.fv_zero", 32'(fetch_valid), 32'd0);
    #1;
    cycle("boot");
    chk("boot.pc", pc_address, 32'h1000);
    cycle("seq1");
    chk("seq1.pc", pc_address, 32'h1004);
    cycle("seq2");
    chk("seq2.pc", pc_address, 32'h1008);

    // backpressure at 0x2000
    drive(0, 3'b001, 32'h2000, 0, 0, 1);
    cycle("go2000");
    drive(0, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp");
      chk("bp.hold", pc_address, 32'h2000);
    end
    drive(0, 3'b000, 0, 0, 0, 1);
    cycle("bp_release");
    chk("bp.adv", pc_address, 32'h2004);

    // priority: ch1 beats ch2
    drive(0, 3'b110, 0, 32'h4000, 32'h8000, 0);
    cycle("prio");
    chk("prio.pc", pc_address, 32'h4000);
    chk("prio.redir", 32'(pc_redirected), 32'd1);
    drive(0, 3'b000, 0, 0, 0, 0);
    cycle("prio_after");
    chk("prio.redir_drop", 32'(pc_redirected), 32'd0);

    // redirects during stall collapse to the newest
    drive(1, 3'b000, 0, 0, 0, 1);
    cycle("st0");
    drive(1, 3'b010, 0, 32'h3000, 0, 1);
    cycle("st1");
    drive(1, 3'b100, 0, 0, 32'h5000, 1);
    cycle("st2");
    drive(1, 3'b000, 0, 0, 0, 1);
    cycle("st3");
    chk("stall.frozen", pc_address, 32'h4000);
    drive(0, 3'b000, 0, 0, 0, 1);
    cycle("st_rel");
    chk("stall.pc", pc_address, 32'h5000);
    chk("stall.redir", 32'(pc_redirected), 32'd1);

    // wrap-around
    drive(0, 3'b001, 32'hFFFF_FFFC, 0, 0, 0);
    cycle("wrap_ld");
    drive(0, 3'b000, 0, 0, 0, 1);
    cycle("wrap");
    chk("wrap.pc", pc_address, 32'h0000_0000);

    // misaligned target
    drive(0, 3'b001, 32'h1006, 0, 0, 0);
    cycle("mis");
    chk("mis.pc", pc_address, MIS_EN ? 32'h1004 : 32'h1006);
    chk("mis.flag", 32'(misalign_err), MIS_EN ? 32'd1 : 32'd0);
    drive(0, 3'b000, 0, 0, 0, 0);
    cycle("mis_after");
    chk("mis.flag_drop", 32'(misalign_err), 32'd0);

    // misaligned capture during stall, loaded from pending
    drive(1, 3'b100, 0, 0, 32'h7003, 0);
    cycle("pmis_cap");
    drive(0, 3'b000, 0, 0, 0, 0);
    cycle("pmis_ld");
    chk("pmis.pc", pc_address, MIS_EN ? 32'h7000 : 32'h7003);

    // randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a [3];
      logic [2:0]  rv;
      for (int k = 0; k < 3; k++) begin
        a[k] = $urandom;
        if ($urandom_range(0, 3) != 0) a[k][1:0] = 2'b00;
        rv[k] = ($urandom_range(0, 99) < 12);
      end
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 25, rv, a[0], a[1], a[2],
            $urandom_range(0, 99) < 70);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
